// File: rtl/csr_buf_pkg.sv
// Shared types and sizing for the CSR sparse-matrix ping-pong buffer.
// A matrix is TOTAL_WORDS 32-bit words: index, indices, then nonzero data.
package csr_buf_pkg;

  localparam int DATA_W      = 32;  // fixed; other widths are not supported
  localparam int IDX_WORDS   = 1;
  localparam int IND_WORDS   = 2;
  localparam int VAL_WORDS   = 16;
  localparam int TOTAL_WORDS = IDX_WORDS + IND_WORDS + VAL_WORDS;
  localparam int MAT_W       = TOTAL_WORDS * DATA_W;
  localparam int PTR_W       = $clog2(TOTAL_WORDS);
  localparam int NUM_BANKS   = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Packed LSB-first in word-slot order, so a flat bank image maps directly:
  // slot 0 -> index, slots 1..2 -> indices, slots 3.. -> data.
  typedef struct packed {
    logic [VAL_WORDS*DATA_W-1:0] data;
    logic [IND_WORDS*DATA_W-1:0] indices;
    logic [IDX_WORDS*DATA_W-1:0] index;
  } csr_mat_t;

endpackage

// File: rtl/csr_bank.sv
// One matrix bank: WORDS x DATA_W register file.
// Ports: clk, rstn (async low), we/addr/wdata write port,
//        rd_flat = all words concatenated, slot 0 in the LSBs.
module csr_bank #(
  parameter int WORDS  = 19,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [WORDS*DATA_W-1:0] rd_flat
);

  logic [WORDS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            mem       <= '0;
    else if (we && (addr < AW'(WORDS)))   mem[addr] <= wdata;
  end

  assign rd_flat = mem;

endmodule

// File: rtl/csr_sparse_buf.sv
// Ping-pong buffer between sparse-matrix DMA and the vector unit.
// Write side: 32-bit word stream (wr_valid_i/wr_data_i/wr_last_i), wr_ready_o
//   high while the current write bank is not FULL.
// Read side: rd_valid_o with the whole matrix in parallel (rd_index_o,
//   rd_indices_o, rd_data_o, zero when not valid); rd_pop_i releases it.
// refill_req_o: one-cycle pulse after each accepted pop.
// full_cnt_o: number of FULL banks. err_o: sticky protocol error, err_clr_i clears.
module csr_sparse_buf
  import csr_buf_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_valid_i,
  input  logic [31:0]  wr_data_i,
  input  logic         wr_last_i,
  output logic         wr_ready_o,
  output logic         rd_valid_o,
  output logic [31:0]  rd_index_o,
  output logic [63:0]  rd_indices_o,
  output logic [511:0] rd_data_o,
  input  logic         rd_pop_i,
  output logic         refill_req_o,
  output logic [1:0]   full_cnt_o,
  output logic         err_o,
  input  logic         err_clr_i
);

  bank_state_e            st_q [NUM_BANKS];
  bank_state_e            st_d [NUM_BANKS];
  logic                   wr_bank_q, rd_bank_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic                   drop_q;     // overran the last slot, discarding until wr_last_i
  logic                   rdy_en_q;   // holds wr_ready_o low while in reset
  logic                   refill_q, err_q;

  logic                   acc, at_end, we, commit, pop_ok, err_ev;
  logic [NUM_BANKS-1:0][MAT_W-1:0] bank_flat;
  csr_mat_t               rd_mat;

  assign wr_ready_o = rdy_en_q && (st_q[wr_bank_q] != FULL);
  assign rd_valid_o = (st_q[rd_bank_q] == FULL);

  assign acc    = wr_valid_i && wr_ready_o;
  assign at_end = (wr_ptr_q == PTR_W'(TOTAL_WORDS - 1));
  assign we     = acc && !drop_q;
  assign commit = acc && wr_last_i;
  assign pop_ok = rd_pop_i && rd_valid_o;

  // Short matrix, overrun, write into a full bank, or pop with nothing valid.
  assign err_ev = (wr_valid_i && !wr_ready_o)
               || (commit && (drop_q || !at_end))
               || (rd_pop_i && !rd_valid_o);

  // Bank FSMs. Commit and pop always hit different banks: a FULL write bank
  // cannot accept, and the read bank is FULL whenever pop is honoured.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) st_d[b] = st_q[b];
    if (acc && st_q[wr_bank_q] == EMPTY) st_d[wr_bank_q] = FILLING;
    if (commit)                          st_d[wr_bank_q] = FULL;
    if (pop_ok)                          st_d[rd_bank_q] = EMPTY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      drop_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
      refill_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= st_d[b];
      rdy_en_q <= 1'b1;
      refill_q <= pop_ok;
      err_q    <= err_ev || (err_q && !err_clr_i);
      if (commit) begin
        wr_bank_q <= ~wr_bank_q;
        wr_ptr_q  <= '0;
        drop_q    <= 1'b0;
      end else if (we) begin
        if (at_end) drop_q   <= 1'b1;
        else        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_bank_q <= ~rd_bank_q;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    csr_bank #(.WORDS(TOTAL_WORDS), .DATA_W(DATA_W), .AW(PTR_W)) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .we      (we && (wr_bank_q == 1'(b))),
      .addr    (wr_ptr_q),
      .wdata   (wr_data_i),
      .rd_flat (bank_flat[b])
    );
  end

  assign rd_mat       = rd_valid_o ? bank_flat[rd_bank_q] : '0;
  assign rd_index_o   = rd_mat.index;
  assign rd_indices_o = rd_mat.indices;
  assign rd_data_o    = rd_mat.data;

  assign refill_req_o = refill_q;
  assign err_o        = err_q;
  assign full_cnt_o   = 2'(st_q[0] == FULL) + 2'(st_q[1] == FULL);

endmodule
